// File: rtl/axi_ddr_rchk.sv
// -----------------------------------------------------------------------------
// axi_ddr_rchk -- AXI4 read-path pattern checker for a DDR/NoC port.
//
// Issues NUM_BURSTS INCR read bursts of BURST_LEN beats each, starting at
// BASE_ADDR, with exactly one burst outstanding at a time. Every returned beat
// is compared against the expected pattern: global beat index k as a 32-bit
// word replicated across the data bus. A beat with bad data, a non-OKAY
// response, a non-zero ID or a misplaced rlast adds one to a saturating error
// count.
//
// Optional feature: define RCHK_TIMEOUT_EN to build a 16-bit watchdog that
// ends a run with timeout=1 after 65535 cycles without an AR or R handshake.
// Without it, timeout is tied to 0.
//
// Ports:
//   aclk, aresetn       clock, synchronous active-low reset
//   start               run request (rising edge, honoured in IDLE/DONE only)
//   busy, done, pass    run status (pass valid while done=1)
//   err_cnt[15:0]       saturating mismatch count
//   timeout             watchdog fired
//   ar*                 AXI read-address master channel
//   r*                  AXI read-data master channel
// -----------------------------------------------------------------------------
module axi_ddr_rchk #(
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned BURST_LEN  = 16,
   parameter int unsigned NUM_BURSTS = 256,
   parameter logic [63:0] BASE_ADDR  = 64'h0
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_cnt,
   output logic              timeout,
   output logic              arvalid,
   input  logic              arready,
   output logic [63:0]       araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [3:0]        arcache,
   output logic [2:0]        arprot,
   output logic [3:0]        arqos,
   output logic              arlock,
   output logic [3:0]        arregion,
   output logic [1:0]        arid,
   output logic [17:0]       aruser,
   input  logic              rvalid,
   output logic              rready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rid,
   input  logic              rlast,
   input  logic [1:0]        rresp
);

   // Byte distance between consecutive bursts; araddr wraps modulo 2^64.
   localparam logic [63:0] STRIDE     = 64'(BURST_LEN) * 64'(DATA_W / 8);
   localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);
   localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);
   localparam logic [2:0]  SIZE       = 3'($clog2(DATA_W / 8));

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t       state_q, state_d;
   logic         start_prev_q, start_prev_d;
   logic [15:0]  burst_q, burst_d;
   logic [7:0]   beat_q, beat_d;
   logic [31:0]  beat_idx_q, beat_idx_d;
   logic [63:0]  araddr_q, araddr_d;
   logic [15:0]  err_cnt_q, err_cnt_d;
   logic         arvalid_q, arvalid_d;
   logic         rready_q, rready_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         pass_q, pass_d;
`ifdef RCHK_TIMEOUT_EN
   logic [15:0]  wdog_q, wdog_d;
   logic         timeout_q, timeout_d;
`endif

   logic              start_edge;
   logic              ar_hs;
   logic              r_hs;
   logic              last_beat;
   logic              beat_bad;
   logic [DATA_W-1:0] exp_data;

   // Expected beat: the 32-bit global beat index in every lane.
   for (genvar gi = 0; gi < int'(DATA_W / 32); gi++) begin : g_exp
      assign exp_data[gi*32 +: 32] = beat_idx_q;
   end

   assign start_edge = start & ~start_prev_q;
   assign ar_hs      = arvalid_q & arready;
   assign r_hs       = rready_q & rvalid;
   assign last_beat  = (beat_q == LAST_BEAT);
   // Any combination of faults on one beat is a single error.
   assign beat_bad   = (rdata != exp_data) | (rresp != 2'b00) |
                       (rid != 2'b00) | (rlast != last_beat);

   always_comb begin
      state_d      = state_q;
      start_prev_d = start;
      burst_d      = burst_q;
      beat_d       = beat_q;
      beat_idx_d   = beat_idx_q;
      araddr_d     = araddr_q;
      err_cnt_d    = err_cnt_q;
`ifdef RCHK_TIMEOUT_EN
      wdog_d       = wdog_q;
      timeout_d    = timeout_q;
`endif

      case (state_q)
         IDLE, DONE: begin
            if (start_edge) begin
               state_d    = ADDR;
               burst_d    = 16'd0;
               beat_d     = 8'd0;
               beat_idx_d = 32'd0;
               araddr_d   = BASE_ADDR;
               err_cnt_d  = 16'd0;
`ifdef RCHK_TIMEOUT_EN
               wdog_d     = 16'd0;
               timeout_d  = 1'b0;
`endif
            end
         end
         ADDR: begin
            if (ar_hs) begin
               state_d = DATA;
               beat_d  = 8'd0;
            end
         end
         DATA: begin
            if (r_hs) begin
               if (beat_bad && (err_cnt_q != 16'hFFFF)) begin
                  err_cnt_d = err_cnt_q + 16'd1;
               end
               beat_idx_d = beat_idx_q + 32'd1;
               // Only the beat counter ends a burst; rlast is merely checked.
               if (last_beat) begin
                  beat_d = 8'd0;
                  if (burst_q == LAST_BURST) begin
                     state_d = DONE;
                  end else begin
                     state_d  = ADDR;
                     burst_d  = burst_q + 16'd1;
                     araddr_d = araddr_q + STRIDE;
                  end
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef RCHK_TIMEOUT_EN
      // The watchdog fires on the edge where it would reach 16'hFFFF.
      if ((state_q == ADDR) || (state_q == DATA)) begin
         if (ar_hs || r_hs) begin
            wdog_d = 16'd0;
         end else if (wdog_q == 16'hFFFE) begin
            wdog_d    = 16'hFFFF;
            state_d   = DONE;
            timeout_d = 1'b1;
         end else begin
            wdog_d = wdog_q + 16'd1;
         end
      end
`endif

      // Status and handshake outputs are registered from the next state.
      arvalid_d = (state_d == ADDR);
      rready_d  = (state_d == DATA);
      busy_d    = (state_d == ADDR) || (state_d == DATA);
      done_d    = (state_d == DONE);
`ifdef RCHK_TIMEOUT_EN
      pass_d    = (state_d == DONE) && (err_cnt_d == 16'd0) && !timeout_d;
`else
      pass_d    = (state_d == DONE) && (err_cnt_d == 16'd0);
`endif
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         // Start held high through reset must not look like an edge.
         start_prev_q <= 1'b1;
         burst_q      <= 16'd0;
         beat_q       <= 8'd0;
         beat_idx_q   <= 32'd0;
         araddr_q     <= 64'd0;
         err_cnt_q    <= 16'd0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
`ifdef RCHK_TIMEOUT_EN
         wdog_q       <= 16'd0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_prev_d;
         burst_q      <= burst_d;
         beat_q       <= beat_d;
         beat_idx_q   <= beat_idx_d;
         araddr_q     <= araddr_d;
         err_cnt_q    <= err_cnt_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
`ifdef RCHK_TIMEOUT_EN
         wdog_q       <= wdog_d;
         timeout_q    <= timeout_d;
`endif
      end
   end

`ifdef RCHK_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_cnt  = err_cnt_q;
   assign arvalid  = arvalid_q;
   assign rready   = rready_q;
   assign araddr   = araddr_q;
   assign arlen    = LAST_BEAT;
   assign arsize   = SIZE;
   assign arburst  = 2'b01;
   assign arcache  = 4'b0011;
   assign arprot   = 3'b000;
   assign arqos    = 4'b0000;
   assign arlock   = 1'b0;
   assign arregion = 4'b0000;
   assign arid     = 2'b00;
   assign aruser   = 18'd0;

endmodule

// File: doc/axi_ddr_rchk.md
AXI_DDR_RCHK -- requirements
Module: axi_ddr_rchk

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, giving the AXI data width in bits (64, 128, 256 or 512).
REQ-002 The block SHALL have parameter BURST_LEN, default 16, giving beats per read burst (1..256).
REQ-003 The block SHALL have parameter NUM_BURSTS, default 256, giving the number of bursts per run (1..65535).
REQ-004 The block SHALL have parameter BASE_ADDR, default 64'h0, giving the byte address of the first burst.
REQ-005 The block SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge aclk.
REQ-006 The block SHALL have port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port start, input, 1 bit: run request, rising-edge detected.
REQ-008 The block SHALL have ports busy, done and pass, outputs, 1 bit each: run status.
REQ-009 The block SHALL have port err_cnt, output, 16 bits: mismatch count, saturating.
REQ-010 The block SHALL have port timeout, output, 1 bit: watchdog fired (see Configuration).
REQ-011 The block SHALL have AR master ports: arvalid (out, 1), arready (in, 1), araddr (out, 64), arlen (out, 8), arsize (out, 3), arburst (out, 2), arcache (out, 4), arprot (out, 3), arqos (out, 4), arlock (out, 1), arregion (out, 4), arid (out, 2), aruser (out, 18).
REQ-012 The block SHALL have R master ports: rvalid (in, 1), rready (out, 1), rdata (in, DATA_W), rid (in, 2), rlast (in, 1), rresp (in, 2).

Function
REQ-013 The FSM SHALL have states IDLE, ADDR, DATA and DONE.
REQ-014 In IDLE or DONE, a 0->1 edge on start SHALL move the FSM to ADDR on the next cycle and clear err_cnt, done, pass and timeout; a start edge in ADDR or DATA SHALL be ignored.
REQ-015 In ADDR, arvalid SHALL be 1 with all AR fields held stable until arready=1; on the handshake the FSM SHALL move to DATA.
REQ-016 Burst i (0-based) SHALL use araddr = BASE_ADDR + i*BURST_LEN*(DATA_W/8), computed modulo 2^64 with wrap-around permitted.
REQ-017 Every burst SHALL use arlen=BURST_LEN-1, arsize=log2(DATA_W/8), arburst=2'b01, arcache=4'b0011, arprot=0, arqos=0, arlock=0, arregion=0, arid=0 and aruser=0.
REQ-018 Exactly one burst SHALL be outstanding at any time.
REQ-019 rready SHALL be 1 in DATA and 0 in every other state.
REQ-020 The expected data for global beat index k (0..NUM_BURSTS*BURST_LEN-1) SHALL be the 32-bit value k replicated DATA_W/32 times.
REQ-021 On each R handshake, err_cnt SHALL increment by 1 if rdata differs from the expected value, rresp!=2'b00, rid!=0, or rlast differs from (beat==BURST_LEN-1); several faults on one beat SHALL count as 1.
REQ-022 err_cnt SHALL saturate at 16'hFFFF.
REQ-023 After beat BURST_LEN-1 is accepted, the FSM SHALL go to ADDR if bursts remain, otherwise to DONE; an early rlast SHALL NOT end the burst.
REQ-024 In DONE, done SHALL be 1, and pass SHALL be 1 iff err_cnt==0 and timeout==0; both SHALL hold until the next start edge.
REQ-025 busy SHALL be 1 in ADDR and DATA, and 0 otherwise.
REQ-026 From a start edge at cycle n, arvalid SHALL first be 1 at cycle n+1.

Reset
REQ-027 While aresetn=0, the FSM SHALL be in IDLE, the burst and beat counters and err_cnt SHALL be 0, and arvalid, rready, busy, done, pass and timeout SHALL be 0.
REQ-028 Reset asserted mid-run SHALL abandon the run without completing outstanding beats; the system SHALL reset the NoC port together with this block.
REQ-029 The start edge detector SHALL reset to its previous-value register = 1, so that start held high through reset does not launch a run.

Configuration
REQ-030 With macro RCHK_TIMEOUT_EN defined, a 16-bit watchdog SHALL count cycles in ADDR/DATA without an AR or R handshake and clear on each handshake.
REQ-031 With RCHK_TIMEOUT_EN defined, when the watchdog reaches 16'hFFFF the FSM SHALL go to DONE with timeout=1 and pass=0.
REQ-032 Without RCHK_TIMEOUT_EN, no watchdog SHALL be built and timeout SHALL be constant 0.

Verification
REQ-033 DATA_W=128, BURST_LEN=4, NUM_BURSTS=2, memory model returns the pattern -> araddr 0x0 then 0x40 with arlen=3 and arsize=4; done=1, pass=1, err_cnt=0.
REQ-034 Same setup, word for beat k=5 corrupted in bit 0 -> err_cnt=1, pass=0.
REQ-035 rresp=2'b10 on one beat, rlast asserted on beat 2 of a 4-beat burst -> err_cnt=2; the FSM still consumes all 4 beats.
REQ-036 arready held 0 for 20 cycles -> arvalid and araddr remain stable throughout; start pulses during this window are ignored.
REQ-037 aresetn=0 for 1 cycle during DATA, start held high -> all outputs 0, no new arvalid until start falls and rises again.
REQ-038 With RCHK_TIMEOUT_EN and rvalid stuck at 0 -> done=1, timeout=1, pass=0 at 65535 cycles after the AR handshake.
